// File: rtl/pzcorebus_pkg.sv
// rtl/pzcorebus_pkg.sv - pzcorebus configuration, command/response types and helpers
package pzcorebus_pkg;

    typedef struct packed {
        int id_width;
        int address_width;
        int length_width;
        int data_width;
        int unit_data_width;
        int request_info_width;
        int response_info_width;
    } pzcorebus_config;

    localparam pzcorebus_config PZCOREBUS_DEFAULT_CONFIG = '{
        id_width:            4,
        address_width:       32,
        length_width:        5,
        data_width:          128,
        unit_data_width:     32,
        request_info_width:  1,
        response_info_width: 1
    };

    typedef enum logic [3:0] {
        PZCOREBUS_NULL_COMMAND          = 4'd0,
        PZCOREBUS_READ                  = 4'd1,
        PZCOREBUS_WRITE                 = 4'd2,
        PZCOREBUS_WRITE_NON_POSTED      = 4'd3,
        PZCOREBUS_FULL_WRITE            = 4'd4,
        PZCOREBUS_FULL_WRITE_NON_POSTED = 4'd5,
        PZCOREBUS_BROADCAST             = 4'd6,
        PZCOREBUS_ATOMIC                = 4'd7,
        PZCOREBUS_ATOMIC_NON_POSTED     = 4'd8,
        PZCOREBUS_MESSAGE               = 4'd9,
        PZCOREBUS_MESSAGE_NON_POSTED    = 4'd10
    } pzcorebus_command_type;

    typedef enum logic [1:0] {
        PZCOREBUS_NULL_RESPONSE      = 2'd0,
        PZCOREBUS_RESPONSE           = 2'd1,
        PZCOREBUS_RESPONSE_WITH_DATA = 2'd2
    } pzcorebus_response_type;

    function automatic logic is_posted(pzcorebus_command_type cmd);
        return cmd inside {PZCOREBUS_WRITE, PZCOREBUS_FULL_WRITE, PZCOREBUS_BROADCAST,
                           PZCOREBUS_ATOMIC, PZCOREBUS_MESSAGE};
    endfunction

    function automatic logic is_non_posted(pzcorebus_command_type cmd);
        return cmd inside {PZCOREBUS_READ, PZCOREBUS_WRITE_NON_POSTED,
                           PZCOREBUS_FULL_WRITE_NON_POSTED, PZCOREBUS_ATOMIC_NON_POSTED,
                           PZCOREBUS_MESSAGE_NON_POSTED};
    endfunction

    function automatic logic has_data(pzcorebus_command_type cmd);
        return cmd inside {PZCOREBUS_WRITE, PZCOREBUS_WRITE_NON_POSTED, PZCOREBUS_FULL_WRITE,
                           PZCOREBUS_FULL_WRITE_NON_POSTED, PZCOREBUS_BROADCAST,
                           PZCOREBUS_ATOMIC, PZCOREBUS_ATOMIC_NON_POSTED};
    endfunction

    function automatic logic response_has_data(pzcorebus_command_type cmd);
        return cmd inside {PZCOREBUS_READ, PZCOREBUS_ATOMIC_NON_POSTED};
    endfunction

    // mlength of zero encodes the maximum length 2^length_width
    function automatic logic [31:0] get_unpacked_length(pzcorebus_config cfg, logic [31:0] mlength);
        logic [31:0] mask;
        logic [31:0] len;
        mask = (32'd1 << cfg.length_width) - 32'd1;
        len  = mlength & mask;
        if (len == 32'd0) begin
            len = mask + 32'd1;
        end
        return len;
    endfunction

    function automatic logic [31:0] get_response_beats(pzcorebus_config cfg, logic [63:0] maddr,
                                                       logic [31:0] mlength);
        logic [31:0] upb;
        logic [31:0] unit_bytes;
        logic [31:0] offset;
        logic [31:0] len;
        upb        = 32'(cfg.data_width / cfg.unit_data_width);
        unit_bytes = 32'(cfg.unit_data_width / 8);
        offset     = 32'((maddr / 64'(unit_bytes)) % 64'(upb));
        len        = get_unpacked_length(cfg, mlength);
        return (offset + len + upb - 32'd1) / upb;
    endfunction

endpackage

// File: rtl/pzcorebus_if.sv
// rtl/pzcorebus_if.sv - pzcorebus command/data/response channel bundle
interface pzcorebus_if
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG = PZCOREBUS_DEFAULT_CONFIG
) ();
    localparam int IW  = BUS_CONFIG.id_width;
    localparam int AW  = BUS_CONFIG.address_width;
    localparam int LW  = BUS_CONFIG.length_width;
    localparam int DW  = BUS_CONFIG.data_width;
    localparam int UW  = BUS_CONFIG.data_width / BUS_CONFIG.unit_data_width;
    localparam int BW  = BUS_CONFIG.data_width / 8;
    localparam int RIW = BUS_CONFIG.request_info_width;
    localparam int SIW = BUS_CONFIG.response_info_width;

    logic                   scmd_accept;
    logic                   mcmd_valid;
    pzcorebus_command_type  mcmd;
    logic [IW-1:0]          mid;
    logic [AW-1:0]          maddr;
    logic [LW-1:0]          mlength;
    logic [RIW-1:0]         minfo;
    logic                   sdata_accept;
    logic                   mdata_valid;
    logic [DW-1:0]          mdata;
    logic [BW-1:0]          mdata_byteen;
    logic                   mdata_last;
    logic                   mresp_accept;
    logic                   sresp_valid;
    pzcorebus_response_type sresp;
    logic [IW-1:0]          sid;
    logic                   serror;
    logic [DW-1:0]          sdata;
    logic [SIW-1:0]         sinfo;
    logic [UW-1:0]          sresp_uniten;
    logic                   sresp_last;

    modport master (
        input  scmd_accept, sdata_accept, sresp_valid, sresp, sid, serror, sdata, sinfo,
               sresp_uniten, sresp_last,
        output mcmd_valid, mcmd, mid, maddr, mlength, minfo, mdata_valid, mdata,
               mdata_byteen, mdata_last, mresp_accept
    );

    modport slave (
        output scmd_accept, sdata_accept, sresp_valid, sresp, sid, serror, sdata, sinfo,
               sresp_uniten, sresp_last,
        input  mcmd_valid, mcmd, mid, maddr, mlength, minfo, mdata_valid, mdata,
               mdata_byteen, mdata_last, mresp_accept
    );
endinterface

// File: rtl/pzcorebus_dummy_slave_resp_counter.sv
// rtl/pzcorebus_dummy_slave_resp_counter.sv - loadable down-counter of remaining response beats
module pzcorebus_dummy_slave_resp_counter #(
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             last,
    output logic             done
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == WIDTH'(1));
    assign done = decrement && last;
endmodule

// File: rtl/pzcorebus_dummy_slave.sv
// rtl/pzcorebus_dummy_slave.sv - terminating pzcorebus responder: drains writes, answers with constant data
module pzcorebus_dummy_slave
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config                BUS_CONFIG     = PZCOREBUS_DEFAULT_CONFIG,
    parameter logic [BUS_CONFIG.data_width-1:0] RESPONSE_DATA  = '0,
    parameter logic                           RESPONSE_ERROR = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    pzcorebus_if.slave slave_if,
    output logic       o_busy
);
    localparam int IW = BUS_CONFIG.id_width;
    localparam int DW = BUS_CONFIG.data_width;
    localparam int CW = BUS_CONFIG.length_width + 1;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        RESP
    } state_t;

    state_t                 state;
    pzcorebus_command_type  cmd;
    logic [IW-1:0]          mid_q;
    logic                   scmd_accept;
    logic                   sdata_accept;
    logic                   sresp_valid;
    pzcorebus_response_type sresp;
    logic [IW-1:0]          sid;
    logic                   serror;
    logic [DW-1:0]          sdata;
    logic                   busy;

    logic                   cmd_ack;
    logic [CW-1:0]          cmd_beats;
    logic                   resp_last;
    logic                   resp_done;

    assign cmd_ack   = (state == IDLE) && slave_if.mcmd_valid;
    assign cmd_beats = (slave_if.mcmd == PZCOREBUS_READ)
                     ? CW'(get_response_beats(BUS_CONFIG, 64'(slave_if.maddr), 32'(slave_if.mlength)))
                     : CW'(1);

    // Loaded for every accepted command; posted commands never decrement it
    pzcorebus_dummy_slave_resp_counter #(
        .WIDTH (CW)
    ) u_resp_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .load       (cmd_ack),
        .load_value (cmd_beats),
        .decrement  (sresp_valid && slave_if.mresp_accept),
        .last       (resp_last),
        .done       (resp_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cmd          <= PZCOREBUS_NULL_COMMAND;
            mid_q        <= '0;
            scmd_accept  <= 1'b1;
            sdata_accept <= 1'b0;
            sresp_valid  <= 1'b0;
            sresp        <= PZCOREBUS_RESPONSE;
            sid          <= '0;
            serror       <= 1'b0;
            sdata        <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (slave_if.mcmd_valid) begin
                        cmd   <= slave_if.mcmd;
                        mid_q <= slave_if.mid;
                        if (has_data(slave_if.mcmd)) begin
                            state        <= WDATA;
                            scmd_accept  <= 1'b0;
                            sdata_accept <= 1'b1;
                            busy         <= 1'b1;
                        end else if (is_non_posted(slave_if.mcmd)) begin
                            state       <= RESP;
                            scmd_accept <= 1'b0;
                            sresp_valid <= 1'b1;
                            sid         <= slave_if.mid;
                            serror      <= RESPONSE_ERROR;
                            sresp       <= response_has_data(slave_if.mcmd)
                                         ? PZCOREBUS_RESPONSE_WITH_DATA : PZCOREBUS_RESPONSE;
                            sdata       <= response_has_data(slave_if.mcmd) ? RESPONSE_DATA : '0;
                            busy        <= 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (slave_if.mdata_valid && slave_if.mdata_last) begin
                        sdata_accept <= 1'b0;
                        if (is_non_posted(cmd)) begin
                            state       <= RESP;
                            sresp_valid <= 1'b1;
                            sid         <= mid_q;
                            serror      <= RESPONSE_ERROR;
                            sresp       <= response_has_data(cmd)
                                         ? PZCOREBUS_RESPONSE_WITH_DATA : PZCOREBUS_RESPONSE;
                            sdata       <= response_has_data(cmd) ? RESPONSE_DATA : '0;
                        end else begin
                            state       <= IDLE;
                            scmd_accept <= 1'b1;
                            busy        <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        state       <= IDLE;
                        scmd_accept <= 1'b1;
                        sresp_valid <= 1'b0;
                        sresp       <= PZCOREBUS_RESPONSE;
                        sid         <= '0;
                        serror      <= 1'b0;
                        sdata       <= '0;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign slave_if.scmd_accept  = scmd_accept;
    assign slave_if.sdata_accept = sdata_accept;
    assign slave_if.sresp_valid  = sresp_valid;
    assign slave_if.sresp        = sresp;
    assign slave_if.sid          = sid;
    assign slave_if.serror       = serror;
    assign slave_if.sdata        = sdata;
    assign slave_if.sinfo        = '0;
    assign slave_if.sresp_uniten = '1;
    assign slave_if.sresp_last   = sresp_valid && resp_last;
    assign o_busy                = busy;

    logic unused_inputs;
    assign unused_inputs = ^{slave_if.minfo, slave_if.mdata, slave_if.mdata_byteen};
endmodule

// File: tb/tb_pzcorebus_dummy_slave.sv
// tb/tb_pzcorebus_dummy_slave.sv - directed self-checking bench for pzcorebus_dummy_slave
module tb_pzcorebus_dummy_slave;
    import pzcorebus_pkg::*;

    localparam pzcorebus_config CFG = '{
        id_width:            4,
        address_width:       32,
        length_width:        5,
        data_width:          128,
        unit_data_width:     32,
        request_info_width:  2,
        response_info_width: 2
    };
    localparam logic [127:0] RDATA = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    pzcorebus_if #(.BUS_CONFIG(CFG)) bus ();

    pzcorebus_dummy_slave #(
        .BUS_CONFIG     (CFG),
        .RESPONSE_DATA  (RDATA),
        .RESPONSE_ERROR (1'b1)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .slave_if (bus),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic send_cmd(input pzcorebus_command_type c, input logic [3:0] id,
                            input logic [31:0] addr, input logic [4:0] len, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.mcmd = c; bus.mid = id; bus.maddr = addr; bus.mlength = len; bus.mcmd_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.scmd_accept) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1;
        bus.mcmd_valid = 1'b0;
    endtask

    task automatic send_data(input int n, output bit ok, output bit cmd_blocked);
        bit got;
        ok = 1'b1;
        cmd_blocked = 1'b1;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            bus.mdata = {4{32'(b + 1)}};
            bus.mdata_byteen = '1;
            bus.mdata_last = (b == n - 1);
            bus.mdata_valid = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                if (bus.scmd_accept) cmd_blocked = 1'b0;
                if (bus.sdata_accept) got = 1'b1;
                else @(negedge clk);
            end
            if (!got) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.mdata_valid = 1'b0;
        bus.mdata_last = 1'b0;
    endtask

    task automatic collect_resp(input int max_cycles, input int stall_beat, input int stall_cycles,
                                output int beats, output int lasts, output int last_beat,
                                output int first_lat, output logic [1:0] resp0,
                                output logic [3:0] id0, output logic err0,
                                output logic [127:0] data0, output bit uniform, output bit held,
                                output bit cmd_blocked);
        int   stall_left = stall_cycles;
        bit   snap_valid = 1'b0;
        logic snap_last = 1'b0;
        beats = 0; lasts = 0; last_beat = 0; first_lat = 0;
        resp0 = '0; id0 = '0; err0 = 1'b0; data0 = '0;
        uniform = 1'b1; held = 1'b1; cmd_blocked = 1'b1;
        for (int cyc = 1; cyc <= max_cycles; cyc++) begin
            @(negedge clk);
            if (bus.sresp_valid) begin
                if (bus.scmd_accept) cmd_blocked = 1'b0;
                if (first_lat == 0) begin
                    first_lat = cyc;
                    resp0 = bus.sresp; id0 = bus.sid; err0 = bus.serror; data0 = bus.sdata;
                end else if ({bus.sresp, bus.sid, bus.serror, bus.sdata} !== {resp0, id0, err0, data0}) begin
                    uniform = 1'b0;
                end
                if (snap_valid && (bus.sresp_last !== snap_last)) held = 1'b0;
                if (beats == stall_beat && stall_left > 0) begin
                    snap_valid = 1'b1;
                    snap_last = bus.sresp_last;
                    stall_left--;
                    bus.mresp_accept = 1'b0;
                end else begin
                    snap_valid = 1'b0;
                    bus.mresp_accept = 1'b1;
                    beats++;
                    if (bus.sresp_last) begin
                        lasts++;
                        last_beat = beats;
                    end
                end
            end else begin
                bus.mresp_accept = 1'b1;
                if (beats > 0) break;
            end
        end
        bus.mresp_accept = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (bus.scmd_accept !== 1'b1) begin failures++; $display("FAIL reset_scmd_accept got %0b want 1", bus.scmd_accept); end
        checks++;
        if (bus.sdata_accept !== 1'b0) begin failures++; $display("FAIL reset_sdata_accept got %0b want 0", bus.sdata_accept); end
        checks++;
        if (bus.sresp_valid !== 1'b0) begin failures++; $display("FAIL reset_sresp_valid got %0b want 0", bus.sresp_valid); end
        checks++;
        if ({bus.sresp, bus.sid, bus.serror} !== {2'd1, 4'd0, 1'b0}) begin
            failures++; $display("FAIL reset_resp_fields got %0h/%0h/%0b want 1/0/0", bus.sresp, bus.sid, bus.serror);
        end
        checks++;
        if ({bus.sdata, bus.sinfo} !== 130'd0) begin failures++; $display("FAIL reset_sdata_sinfo got %0h/%0h want 0", bus.sdata, bus.sinfo); end
        checks++;
        if ({bus.sresp_uniten, bus.sresp_last, busy} !== 6'b111100) begin
            failures++; $display("FAIL reset_uniten_last_busy got %0h/%0b/%0b want f/0/0", bus.sresp_uniten, bus.sresp_last, busy);
        end
        checks++;
        rst = 1'b0;
    endtask

    task automatic run_read(input string name, input logic [3:0] id, input logic [31:0] addr,
                            input logic [4:0] len, input int exp_beats, input int stall_beat,
                            input int stall_cycles);
        bit ok, uniform, held, blocked;
        int beats, lasts, last_beat, lat;
        logic [1:0] r; logic [3:0] sid; logic err; logic [127:0] d;
        send_cmd(PZCOREBUS_READ, id, addr, len, ok);
        collect_resp(60, stall_beat, stall_cycles, beats, lasts, last_beat, lat, r, sid, err, d, uniform, held, blocked);
        if (!ok || beats != exp_beats) begin failures++; $display("FAIL %s_beats got %0d want %0d (accepted=%0b)", name, beats, exp_beats, ok); end
        checks++;
        if (lasts != 1 || last_beat != exp_beats) begin
            failures++; $display("FAIL %s_last got count=%0d at beat %0d want 1 at beat %0d", name, lasts, last_beat, exp_beats);
        end
        checks++;
        if ({r, sid, err, d} !== {2'd2, id, 1'b1, RDATA}) begin
            failures++; $display("FAIL %s_fields got resp=%0h sid=%0h err=%0b data=%0h want 2/%0h/1/%0h", name, r, sid, err, d, id, RDATA);
        end
        checks++;
        if (lat != 1 || !uniform || !held || !blocked) begin
            failures++; $display("FAIL %s_timing got lat=%0d uniform=%0b held=%0b blocked=%0b want 1/1/1/1", name, lat, uniform, held, blocked);
        end
        checks++;
        if (bus.scmd_accept !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL %s_idle_after got scmd_accept=%0b busy=%0b want 1/0", name, bus.scmd_accept, busy);
        end
        checks++;
    endtask

    task automatic test_read_basic();
        run_read("read_basic", 4'd5, 32'h0, 5'd8, 2, 99, 0);
    endtask

    task automatic test_read_offset();
        run_read("read_offset", 4'd6, 32'h8, 5'd4, 2, 99, 0);
    endtask

    task automatic test_read_max_stall();
        run_read("read_max_stall", 4'd7, 32'h0, 5'd0, 8, 3, 3);
    endtask

    task automatic test_back_to_back();
        run_read("read_one_unit", 4'd9, 32'hC, 5'd1, 1, 99, 0);
        run_read("read_cross_beat", 4'd10, 32'hC, 5'd2, 2, 99, 0);
    endtask

    task automatic run_write(input string name, input pzcorebus_command_type c, input logic [3:0] id,
                             input int nbeats, input logic [1:0] exp_resp, input logic [127:0] exp_data);
        bit ok, dok, dblk, uniform, held, blocked;
        int beats, lasts, last_beat, lat;
        logic [1:0] r; logic [3:0] sid; logic err; logic [127:0] d;
        send_cmd(c, id, 32'h40, 5'd4, ok);
        send_data(nbeats, dok, dblk);
        if (!ok || !dok || !dblk) begin
            failures++; $display("FAIL %s_accept got cmd=%0b data=%0b cmd_blocked=%0b want 1/1/1", name, ok, dok, dblk);
        end
        checks++;
        collect_resp(20, 99, 0, beats, lasts, last_beat, lat, r, sid, err, d, uniform, held, blocked);
        if (beats != 1 || lasts != 1 || lat != 1 || !blocked) begin
            failures++; $display("FAIL %s_beats got beats=%0d lasts=%0d lat=%0d blocked=%0b want 1/1/1/1", name, beats, lasts, lat, blocked);
        end
        checks++;
        if ({r, sid, err, d} !== {exp_resp, id, 1'b1, exp_data}) begin
            failures++; $display("FAIL %s_fields got resp=%0h sid=%0h err=%0b data=%0h want %0h/%0h/1/%0h", name, r, sid, err, d, exp_resp, id, exp_data);
        end
        checks++;
        if (bus.scmd_accept !== 1'b1) begin failures++; $display("FAIL %s_idle_after got scmd_accept=%0b want 1", name, bus.scmd_accept); end
        checks++;
    endtask

    task automatic test_write_non_posted();
        run_write("write_np", PZCOREBUS_WRITE_NON_POSTED, 4'd3, 3, 2'd1, 128'd0);
    endtask

    task automatic test_atomic_non_posted();
        run_write("atomic_np", PZCOREBUS_ATOMIC_NON_POSTED, 4'd12, 1, 2'd2, RDATA);
    endtask

    task automatic run_silent(input string name, input pzcorebus_command_type c, input int nbeats);
        bit ok, dok, dblk, uniform, held, blocked;
        int beats, lasts, last_beat, lat;
        logic [1:0] r; logic [3:0] sid; logic err; logic [127:0] d;
        send_cmd(c, 4'd2, 32'h0, 5'd8, ok);
        dok = 1'b1;
        if (nbeats > 0) send_data(nbeats, dok, dblk);
        @(negedge clk);
        if (!ok || !dok || bus.scmd_accept !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL %s_free got cmd=%0b data=%0b scmd_accept=%0b busy=%0b want 1/1/1/0", name, ok, dok, bus.scmd_accept, busy);
        end
        checks++;
        collect_resp(6, 99, 0, beats, lasts, last_beat, lat, r, sid, err, d, uniform, held, blocked);
        if (beats != 0 || lat != 0) begin failures++; $display("FAIL %s_no_resp got beats=%0d lat=%0d want 0/0", name, beats, lat); end
        checks++;
    endtask

    task automatic test_posted_write();
        run_silent("posted_write", PZCOREBUS_WRITE, 2);
    endtask

    task automatic test_message();
        bit ok, uniform, held, blocked;
        int beats, lasts, last_beat, lat;
        logic [1:0] r; logic [3:0] sid; logic err; logic [127:0] d;
        run_silent("message", PZCOREBUS_MESSAGE, 0);
        send_cmd(PZCOREBUS_MESSAGE_NON_POSTED, 4'd11, 32'h0, 5'd1, ok);
        collect_resp(20, 99, 0, beats, lasts, last_beat, lat, r, sid, err, d, uniform, held, blocked);
        if (!ok || beats != 1 || lasts != 1 || {r, sid, err, d} !== {2'd1, 4'd11, 1'b1, 128'd0}) begin
            failures++; $display("FAIL message_np got beats=%0d lasts=%0d resp=%0h sid=%0h err=%0b want 1/1/1/b/1", beats, lasts, r, sid, err);
        end
        checks++;
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        send_cmd(PZCOREBUS_READ, 4'd8, 32'h0, 5'd0, ok);
        @(negedge clk);
        if (!ok || bus.sresp_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_first_beat got valid=%0b want 1", bus.sresp_valid); end
        checks++;
        rst = 1'b1;
        @(negedge clk);
        if ({bus.sresp_valid, bus.scmd_accept, busy, bus.sdata_accept} !== 4'b0100) begin
            failures++; $display("FAIL rst_mid_state got valid=%0b scmd_accept=%0b busy=%0b sdata_accept=%0b want 0/1/0/0",
                                 bus.sresp_valid, bus.scmd_accept, busy, bus.sdata_accept);
        end
        checks++;
        rst = 1'b0;
        run_read("read_after_rst", 4'd4, 32'h0, 5'd4, 1, 99, 0);
    endtask

    initial begin
        bus.mcmd_valid = 1'b0; bus.mcmd = PZCOREBUS_NULL_COMMAND; bus.mid = '0; bus.maddr = '0;
        bus.mlength = '0; bus.minfo = '0; bus.mdata_valid = 1'b0; bus.mdata = '0;
        bus.mdata_byteen = '0; bus.mdata_last = 1'b0; bus.mresp_accept = 1'b1;
        test_reset();
        test_read_basic();
        test_read_offset();
        test_read_max_stall();
        test_back_to_back();
        test_write_non_posted();
        test_atomic_non_posted();
        test_posted_write();
        test_message();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
